// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus per-bit stability-counter debouncer for slide switches.
// Define SW_DEBOUNCE_EDGE_EN to build the registered rise/fall pulse outputs.
module sw_debounce #(
  parameter int N         = 10,
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 19
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic [N-1:0] SW,
  output logic [N-1:0] SW_db,
  output logic [N-1:0] SW_rise,
  output logic [N-1:0] SW_fall
);

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } db_state_e;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N-1:0]     r_s1;
  logic [N-1:0]     r_s2;
  logic [N-1:0]     r_stable;
  logic [CNT_W-1:0] r_cnt      [N];

  db_state_e        w_state    [N];
  logic [N-1:0]     w_stable_nxt;
  logic [CNT_W-1:0] w_cnt_nxt  [N];

  // NOTE: every output of this block gets a default before any branch, so no
  // path can leave a variable unassigned and infer a latch.
  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < N; i++) begin
      w_cnt_nxt[i] = '0;
      w_state[i]   = (r_s2[i] == r_stable[i]) ? ST_IDLE : ST_PENDING;
      case (w_state[i])
        ST_IDLE: w_cnt_nxt[i] = '0;
        ST_PENDING: begin
          if (r_cnt[i] == LP_CNT_LAST) begin
            w_stable_nxt[i] = r_s2[i];
            w_cnt_nxt[i]    = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        default: w_cnt_nxt[i] = '0;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so s2 samples the old s1
  // and every bit reads pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_stable <= '0;
      // NOTE: the counter array is reset explicitly; it is small per-bit state,
      // not a RAM, and a stale count would give partial credit after reset.
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      r_s1     <= SW;
      r_s2     <= r_s1;
      r_stable <= w_stable_nxt;
      for (int i = 0; i < N; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign SW_db = r_stable;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic [N-1:0] r_stable_prev;
  logic [N-1:0] r_rise;
  logic [N-1:0] r_fall;

  // Pulses land one cycle after the debounced level changes.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_stable_prev <= '0;
      r_rise        <= '0;
      r_fall        <= '0;
    end else begin
      r_stable_prev <= r_stable;
      r_rise        <= r_stable & ~r_stable_prev;
      r_fall        <= ~r_stable & r_stable_prev;
    end
  end

  assign SW_rise = r_rise;
  assign SW_fall = r_fall;
`else
  assign SW_rise = '0;
  assign SW_fall = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DB_CYCLES=4 (five-edge acceptance latency).
// Edge-pulse expectations follow whether SW_DEBOUNCE_EDGE_EN is defined.
module tb_sw_debounce;

  localparam int N = 10;
`ifdef SW_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [N-1:0] sw;
  logic [N-1:0] sw_db;
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;

  int tests = 0;
  int fails = 0;

  sw_debounce #(.N(N), .DB_CYCLES(4), .CNT_W(3)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .SW       (sw),
    .SW_db    (sw_db),
    .SW_rise  (sw_rise),
    .SW_fall  (sw_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [N-1:0] sw;
    logic [N-1:0] db;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } vec_t;

  vec_t vecs[33];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change away from the edge; outputs are sampled 1 ns after it.
  task automatic step(input logic rst_v, input logic [N-1:0] sw_v);
    reset = rst_v;
    sw    = sw_v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] edge_exp(input logic [N-1:0] v);
    return EDGE_EN ? v : '0;
  endfunction

  function automatic vec_t mk(input logic rst, input logic [N-1:0] s, input logic [N-1:0] db,
                              input logic [N-1:0] rise, input logic [N-1:0] fall);
    vec_t v;
    v.rst = rst; v.sw = s; v.db = db; v.rise = edge_exp(rise); v.fall = edge_exp(fall);
    return v;
  endfunction

  initial begin
    int first_hi;
    int transitions;
    int rise_cnt;
    logic prev_db1;
    logic [N-1:0] bsw;

    reset = 1'b1;
    sw    = '0;

    // Reset with all switches high, then bit 9 clean rise (edge 3 captures it).
    for (int i = 0; i < 3; i++) vecs[i] = mk(1'b1, 10'h3FF, 10'h000, 10'h000, 10'h000);
    for (int i = 3; i < 8; i++) vecs[i] = mk(1'b0, 10'h200, 10'h000, 10'h000, 10'h000);
    vecs[8]  = mk(1'b0, 10'h200, 10'h200, 10'h000, 10'h000);
    vecs[9]  = mk(1'b0, 10'h200, 10'h200, 10'h200, 10'h000);
    vecs[10] = mk(1'b0, 10'h200, 10'h200, 10'h000, 10'h000);
    vecs[11] = mk(1'b0, 10'h200, 10'h200, 10'h000, 10'h000);
    // Two-cycle glitch on bit 0 is rejected.
    vecs[12] = mk(1'b0, 10'h201, 10'h200, 10'h000, 10'h000);
    vecs[13] = mk(1'b0, 10'h201, 10'h200, 10'h000, 10'h000);
    for (int i = 14; i < 17; i++) vecs[i] = mk(1'b0, 10'h200, 10'h200, 10'h000, 10'h000);
    // Held bit 0 (captured at 17) needs the full count again.
    for (int i = 17; i < 22; i++) vecs[i] = mk(1'b0, 10'h201, 10'h200, 10'h000, 10'h000);
    vecs[22] = mk(1'b0, 10'h201, 10'h201, 10'h000, 10'h000);
    vecs[23] = mk(1'b0, 10'h201, 10'h201, 10'h001, 10'h000);
    vecs[24] = mk(1'b0, 10'h201, 10'h201, 10'h000, 10'h000);
    // Bit 9 released (captured at 25) gives a fall.
    for (int i = 25; i < 30; i++) vecs[i] = mk(1'b0, 10'h001, 10'h201, 10'h000, 10'h000);
    vecs[30] = mk(1'b0, 10'h001, 10'h001, 10'h000, 10'h000);
    vecs[31] = mk(1'b0, 10'h001, 10'h001, 10'h000, 10'h200);
    vecs[32] = mk(1'b0, 10'h001, 10'h001, 10'h000, 10'h000);

    @(negedge clk);
    for (int i = 0; i < 33; i++) begin
      step(vecs[i].rst, vecs[i].sw);
      check($sformatf("vec%0d db", i),   sw_db,   vecs[i].db);
      check($sformatf("vec%0d rise", i), sw_rise, vecs[i].rise);
      check($sformatf("vec%0d fall", i), sw_fall, vecs[i].fall);
    end

    // Bounce train on bit 1: 3-cycle runs for 30 cycles, then held high at step 30.
    first_hi    = -1;
    transitions = 0;
    rise_cnt    = 0;
    prev_db1    = sw_db[1];
    for (int j = 0; j < 40; j++) begin
      bsw    = 10'h001;
      bsw[1] = (j >= 30) ? 1'b1 : (((j / 3) % 2) == 0);
      step(1'b0, bsw);
      if (sw_db[1] && !prev_db1) begin
        transitions++;
        if (first_hi < 0) first_hi = j;
      end
      if (sw_rise[1]) rise_cnt++;
      prev_db1 = sw_db[1];
    end
    check("bounce accept step", N'(first_hi), N'(35));
    check("bounce transitions", N'(transitions), N'(1));
    check("bounce rise pulses", N'(rise_cnt), EDGE_EN ? N'(1) : N'(0));
    check("bounce final db", sw_db, 10'h003);

    // Reset while bit 2 is mid-count (cnt reaches 2 after the fourth edge).
    for (int j = 0; j < 4; j++) step(1'b0, 10'h007);
    check("midcount pre-reset db", sw_db, 10'h003);
    step(1'b1, 10'h007);
    check("midcount reset db", sw_db, 10'h000);
    check("midcount reset rise", sw_rise, 10'h000);
    check("midcount reset fall", sw_fall, 10'h000);
    for (int j = 0; j < 5; j++) step(1'b0, 10'h007);
    check("post-reset db before full count", sw_db, 10'h000);
    step(1'b0, 10'h007);
    check("post-reset db after full count", sw_db, 10'h007);
    step(1'b0, 10'h007);
    check("post-reset rise", sw_rise, edge_exp(10'h007));
    check("post-reset fall", sw_fall, 10'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-conditioning stage between the board slide switches and the 2-to-1 mux datapath.
- Synchronises each raw switch level into the clock domain and debounces it.
- Presents clean, stable levels: data bits go to the mux data inputs, bit 9 goes to the select.
- Optionally produces one-cycle rise/fall pulses for later counter/FSM labs.

Parameters:
- N, 10, number of switch bits conditioned.
- DB_CYCLES, 500000, consecutive stable cycles required before a new level is accepted (10 ms at 50 MHz); legal range 1 to 2^CNT_W-1.
- CNT_W, 19, width of each per-bit stability counter.

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- SW  input  N  raw asynchronous switch levels
- SW_db  output  N  debounced switch levels, feeds mux x/y/s
- SW_rise  output  N  one-cycle pulse when SW_db bit goes 0->1
- SW_fall  output  N  one-cycle pulse when SW_db bit goes 1->0

Behaviour:
- Per bit, independent logic replicated N times: two-flop synchroniser s1 <= SW, s2 <= s1; stable register (drives SW_db); counter cnt[CNT_W-1:0].
- Reset (sampled high at a rising edge): s1, s2, stable, cnt, SW_db, SW_rise and SW_fall all become 0 on that edge. Reset overrides all other activity, including mid-count. After reset deasserts, a switch held at 1 is accepted by the normal debounce path, not instantly.
- Per-bit FSM, two implicit states:
  - IDLE (s2 == stable): cnt <= 0.
  - PENDING (s2 != stable): cnt <= cnt+1. At the edge where cnt == DB_CYCLES-1 and s2 is still != stable: stable <= s2, cnt <= 0.
- Glitch rejection: if s2 returns to stable before the count completes, cnt clears to 0 on the next edge. A later change restarts the count from 0, with no partial credit.
- Latency: SW_db changes on the edge DB_CYCLES+1 edges after the edge that first captures the new level into s1. The level must be held constant throughout.
- Counter never wraps: it is cleared at DB_CYCLES-1. Widths must satisfy DB_CYCLES <= 2^CNT_W-1 (checked by the verification engineer's assertion).
- Bits are fully independent; simultaneous changes on several bits each complete on their own schedule.
- SW_rise[i]: high for exactly the one cycle after the edge where stable[i] goes 0->1 (registered: stable_prev <= stable; rise = stable & ~stable_prev). SW_fall is symmetric.

Optional Feature:
- Macro SW_DEBOUNCE_EDGE_EN.
- Defined: SW_rise/SW_fall behave as above; stable_prev registers are instantiated and reset to 0.
- Undefined: SW_rise and SW_fall are tied constant 0, no stable_prev registers are instantiated, and SW_db behaviour is identical.

Test Plan:
- Reset: bench overrides DB_CYCLES=4, CNT_W=3. Drive SW=10'h3FF with reset high for 3 cycles -> SW_db=0, SW_rise=0, SW_fall=0 on every cycle reset is sampled.
- Clean change: after reset, set SW[9]=1 before edge k and hold -> SW_db[9]=1 first seen after edge k+5. With macro, SW_rise[9]=1 for exactly the cycle after edge k+6; other bits stay 0.
- Glitch: SW[0]=1 for 2 cycles, then 0 -> SW_db[0] never changes, SW_rise[0] stays 0, cnt returns to 0. Then hold SW[0]=1 -> accepted after the full 5-edge latency, with no partial credit.
- Bounce train: toggle SW[1] every 3 cycles for 30 cycles, then hold 1 -> exactly one 0->1 transition on SW_db[1], occurring 5 edges after the final toggle is captured.
- Reset mid-count: SW[2]=1 held. Assert reset when cnt==2 -> cnt, stable, SW_db[2]=0. After deassert, SW_db[2]=1 occurs only after a fresh full count.
- Macro off: rebuild without SW_DEBOUNCE_EDGE_EN and repeat the clean-change scenario -> SW_db timing identical, SW_rise and SW_fall constantly 10'h000.
